// File: rtl/instr_seq_pkg.sv
// Shared types and constants for the instr_seq multi-cycle sequencer.
// Optional watchdog build macro: INSTR_SEQ_WDT_EN.
package instr_seq_pkg;

  localparam int unsigned STATE_W         = 3;
  localparam int unsigned ICOUNT_W        = 16;
  localparam int unsigned WAIT_W          = 8;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERR    = 3'd7
  } state_e;

  // Instruction-class flags captured in DECODE
  typedef struct packed {
    logic ld;
    logic st;
    logic wb;
  } op_flags_t;

  // States that wait on a memory done strobe
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/instr_seq_wait_timer.sv
// Memory-wait watchdog counter: clear / count-enable / terminal count.
// Only instantiated when INSTR_SEQ_WDT_EN is defined.
module wait_timer
  import instr_seq_pkg::*;
#(
  parameter int unsigned TC = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CMP_W = WAIT_W + 1;

  logic [WAIT_W-1:0] cnt;

  // Wait-cycle counter; sync active-low reset
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + WAIT_W'(1);
    end
  end

  // Fires in the waiting cycle that brings the count up to TC
  assign tc_c = en && ((CMP_W'(cnt) + CMP_W'(1)) == CMP_W'(TC));

endmodule

// File: rtl/instr_seq.sv
// WISC-SP13 multi-cycle sequencer: FETCH, DECODE, EXEC, MEM, WB.
// Optional memory-wait watchdog enabled by defining INSTR_SEQ_WDT_EN.
module instr_seq
  import instr_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                imem_done,
  input  logic                dmem_done,
  input  logic                op_ld,
  input  logic                op_st,
  input  logic                op_wb,
  input  logic                op_halt,
  input  logic                dec_err,
  output logic                imem_en,
  output logic                ir_load,
  output logic                dmem_en,
  output logic                dmem_wr,
  output logic                rf_write,
  output logic                pc_en,
  output logic                createdump,
  output logic                halted,
  output logic                error,
  output logic [ICOUNT_W-1:0] icount
);

  // Reject an out-of-range watchdog limit at elaboration
  if ((TIMEOUT == 0) || (TIMEOUT > ((32'd1 << WAIT_W) - 32'd1))) begin : g_timeout_range
    $error("instr_seq: TIMEOUT must be 1..255");
  end

  state_e              state;
  state_e              state_d;
  op_flags_t           flags;
  op_flags_t           flags_d;
  logic [ICOUNT_W-1:0] icount_q;
  logic                wdt_expire_c;

`ifdef INSTR_SEQ_WDT_EN
  logic in_wait_c;
  logic wait_done_c;

  assign in_wait_c   = is_wait_state(state);
  assign wait_done_c = (state == ST_FETCH) ? imem_done : dmem_done;

  wait_timer #(
    .TC (TIMEOUT)
  ) u_wait_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (!in_wait_c || wait_done_c),
    .en   (in_wait_c && !wait_done_c),
    .tc_c (wdt_expire_c)
  );
`else
  assign wdt_expire_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Class flags and retired-instruction counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      flags    <= '0;
      icount_q <= '0;
    end else begin
      flags <= flags_d;
      if (pc_en) begin
        icount_q <= icount_q + ICOUNT_W'(1);
      end
    end
  end

  // Next-state and stage-enable decode
  always_comb begin
    state_d    = state;
    flags_d    = flags;
    imem_en    = 1'b0;
    ir_load    = 1'b0;
    dmem_en    = 1'b0;
    dmem_wr    = 1'b0;
    rf_write   = 1'b0;
    pc_en      = 1'b0;
    createdump = 1'b0;
    halted     = 1'b0;
    error      = 1'b0;

    case (state)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        imem_en = 1'b1;
        if (imem_done) begin
          ir_load = 1'b1;
          state_d = ST_DECODE;
        end else if (wdt_expire_c) begin
          state_d = ST_ERR;
        end
      end

      ST_DECODE: begin
        flags_d.ld = op_ld;
        flags_d.st = op_st;
        flags_d.wb = op_wb;
        if (dec_err) begin
          state_d = ST_ERR;
        end else if (op_halt) begin
          createdump = 1'b1;
          state_d    = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (flags.ld && flags.st) begin
          state_d = ST_ERR;
        end else if (flags.ld || flags.st) begin
          state_d = ST_MEM;
        end else if (flags.wb) begin
          state_d = ST_WB;
        end else begin
          pc_en   = 1'b1;
          state_d = ST_FETCH;
        end
      end

      ST_MEM: begin
        dmem_en = 1'b1;
        dmem_wr = flags.st;
        if (dmem_done) begin
          if (flags.ld) begin
            state_d = ST_WB;
          end else begin
            pc_en   = 1'b1;
            state_d = ST_FETCH;
          end
        end else if (wdt_expire_c) begin
          state_d = ST_ERR;
        end
      end

      ST_WB: begin
        rf_write = 1'b1;
        pc_en    = 1'b1;
        state_d  = ST_FETCH;
      end

      ST_HALT: begin
        halted = 1'b1;
      end

      ST_ERR: begin
        error = 1'b1;
      end

      default: begin
        state_d = ST_ERR;
      end
    endcase
  end

  assign icount = icount_q;

endmodule

// File: tb/tb_instr_seq.sv
// Self-checking bench for instr_seq: per-instruction expected cycle traces
// built from the sequencing rules, checked by a decoupled monitor.
module tb_instr_seq;

  localparam int C_ALU      = 0;
  localparam int C_ALU_WB   = 1;
  localparam int C_LOAD     = 2;
  localparam int C_STORE    = 3;
  localparam int C_HALT     = 4;
  localparam int C_DERR     = 5;
  localparam int C_LDST     = 6;
  localparam int C_HALT_ERR = 7;

`ifdef INSTR_SEQ_WDT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 0;
`endif

  // Output flag bits: {imem_en, ir_load, dmem_en, dmem_wr, rf_write, pc_en, createdump, halted, error}
  localparam logic [8:0] O_IMEM = 9'h100;
  localparam logic [8:0] O_IR   = 9'h080;
  localparam logic [8:0] O_DMEM = 9'h040;
  localparam logic [8:0] O_DWR  = 9'h020;
  localparam logic [8:0] O_RFW  = 9'h010;
  localparam logic [8:0] O_PC   = 9'h008;
  localparam logic [8:0] O_DUMP = 9'h004;
  localparam logic [8:0] O_HALT = 9'h002;
  localparam logic [8:0] O_ERR  = 9'h001;

  typedef struct packed {
    logic [8:0]  f;
    logic [15:0] icount;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_done = 1'b0;
  logic        dmem_done = 1'b0;
  logic        op_ld = 1'b0;
  logic        op_st = 1'b0;
  logic        op_wb = 1'b0;
  logic        op_halt = 1'b0;
  logic        dec_err = 1'b0;
  logic        imem_en;
  logic        ir_load;
  logic        dmem_en;
  logic        dmem_wr;
  logic        rf_write;
  logic        pc_en;
  logic        createdump;
  logic        halted;
  logic        error;
  logic [15:0] icount;

  obs_t        exp_q[$];
  string       tag_q[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] mdl_icount = '0;

  instr_seq #(
    .TIMEOUT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_done  (imem_done),
    .dmem_done  (dmem_done),
    .op_ld      (op_ld),
    .op_st      (op_st),
    .op_wb      (op_wb),
    .op_halt    (op_halt),
    .dec_err    (dec_err),
    .imem_en    (imem_en),
    .ir_load    (ir_load),
    .dmem_en    (dmem_en),
    .dmem_wr    (dmem_wr),
    .rf_write   (rf_write),
    .pc_en      (pc_en),
    .createdump (createdump),
    .halted     (halted),
    .error      (error),
    .icount     (icount)
  );

  always #5 clk = ~clk;

  // Monitor: one expected observation per cycle, compared mid-cycle
  always @(negedge clk) begin
    obs_t  e;
    obs_t  a;
    string t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a.f      = {imem_en, ir_load, dmem_en, dmem_wr, rf_write, pc_en, createdump, halted, error};
      a.icount = icount;
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s @%0t: actual flags=%b icount=%0d required flags=%b icount=%0d",
                 t, $time, a.f, a.icount, e.f, e.icount);
      end
    end
  end

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [4:0] junk();
    return 5'($urandom);
  endfunction

  // One cycle: drive inputs after the edge, queue what the outputs must be
  task automatic step(input logic r, input logic id, input logic dd, input logic [4:0] ops,
                      input logic [8:0] f, input string tag);
    obs_t e;
    @(posedge clk);
    #1;
    rst       = r;
    imem_done = id;
    dmem_done = dd;
    {op_ld, op_st, op_wb, op_halt, dec_err} = ops;
    e.f      = f;
    e.icount = mdl_icount;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if ((f & O_PC) != 9'h000) mdl_icount = mdl_icount + 16'd1;
  endtask

  // Caller has just driven rst low; n-1 more low cycles then the release (IDLE) cycle
  task automatic reset_seq(input int n);
    mdl_icount = '0;
    for (int i = 0; i < n - 1; i++) step(1'b0, rb(), rb(), junk(), 9'h000, "rst_low");
    step(1'b1, rb(), rb(), junk(), 9'h000, "rst_idle");
  endtask

  // Absorbing HALT/ERR: flag held, done inputs ignored, then reset
  task automatic absorb(input logic [8:0] flag, input string tag);
    int k;
    k = $urandom_range(2, 4);
    for (int i = 0; i < k; i++) step((i == k - 1) ? 1'b0 : 1'b1, rb(), rb(), junk(), flag, tag);
    reset_seq($urandom_range(1, 3));
  endtask

  // Full expected life of one instruction; abort_at 1/2 resets during fetch/mem wait
  task automatic run_instr(input int cls, input int fw, input int mw, input int abort_at);
    logic ld, st, wb, hlt, de;
    logic [8:0] dw;
    ld = 1'b0; st = 1'b0; wb = rb(); hlt = 1'b0; de = 1'b0;
    case (cls)
      C_ALU:      wb = 1'b0;
      C_ALU_WB:   wb = 1'b1;
      C_LOAD:     ld = 1'b1;
      C_STORE:    st = 1'b1;
      C_HALT:     begin hlt = 1'b1; ld = rb(); st = rb(); end
      C_DERR:     begin de = 1'b1; ld = rb(); st = rb(); hlt = rb(); end
      C_LDST:     begin ld = 1'b1; st = 1'b1; end
      default:    begin hlt = 1'b1; de = 1'b1; end
    endcase

    for (int i = 0; i < fw; i++) begin
      if (abort_at == 1 && i == fw - 1) begin
        step(1'b0, 1'b0, rb(), junk(), O_IMEM, "fetch_abort");
        reset_seq($urandom_range(1, 3));
        return;
      end
      step(1'b1, 1'b0, rb(), junk(), O_IMEM, "fetch_wait");
      if (TMO != 0 && i + 1 == TMO) begin
        absorb(O_ERR, "fetch_timeout");
        return;
      end
    end
    step(1'b1, 1'b1, rb(), junk(), O_IMEM | O_IR, "fetch_done");

    step(1'b1, rb(), rb(), {ld, st, wb, hlt, de}, (hlt && !de) ? O_DUMP : 9'h000, "decode");
    if (de) begin
      absorb(O_ERR, "dec_error");
      return;
    end
    if (hlt) begin
      absorb(O_HALT, "halted");
      return;
    end

    if (ld && st) begin
      step(1'b1, rb(), rb(), junk(), 9'h000, "exec_ldst");
      absorb(O_ERR, "ldst_error");
      return;
    end
    if (!ld && !st && !wb) begin
      step(1'b1, rb(), rb(), junk(), O_PC, "exec_retire");
      return;
    end
    step(1'b1, rb(), rb(), junk(), 9'h000, "exec");

    if (ld || st) begin
      dw = st ? O_DWR : 9'h000;
      for (int i = 0; i < mw; i++) begin
        if (abort_at == 2 && i == mw - 1) begin
          step(1'b0, rb(), 1'b0, junk(), O_DMEM | dw, "mem_abort");
          reset_seq($urandom_range(1, 3));
          return;
        end
        step(1'b1, rb(), 1'b0, junk(), O_DMEM | dw, "mem_wait");
        if (TMO != 0 && i + 1 == TMO) begin
          absorb(O_ERR, "mem_timeout");
          return;
        end
      end
      step(1'b1, rb(), 1'b1, junk(), O_DMEM | dw | (st ? O_PC : 9'h000), "mem_done");
      if (st) return;
    end

    step(1'b1, rb(), rb(), junk(), O_RFW | O_PC, "writeback");
  endtask

  initial begin
    int r, cls, fw, mw, ab;

    // Reset low over three edges, then one IDLE cycle before FETCH
    reset_seq(3);

    // Directed cases
    run_instr(C_ALU_WB, 0, 0, 0);
    run_instr(C_LOAD,   0, 3, 0);
    run_instr(C_STORE,  1, 2, 0);
    run_instr(C_ALU,    2, 0, 0);
    run_instr(C_STORE,  0, 0, 0);
    run_instr(C_LOAD,   3, 1, 1);
    run_instr(C_STORE,  0, 3, 2);
    run_instr(C_ALU_WB, 0, 0, 0);
    run_instr(C_HALT,   0, 0, 0);
    run_instr(C_HALT_ERR, 1, 0, 0);
    run_instr(C_LDST,   0, 0, 0);
    run_instr(C_DERR,   0, 0, 0);
`ifdef INSTR_SEQ_WDT_EN
    run_instr(C_ALU,    4, 0, 0);
    run_instr(C_ALU,    3, 0, 0);
    run_instr(C_LOAD,   0, 4, 0);
    run_instr(C_STORE,  0, 3, 0);
`endif

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      r   = $urandom_range(0, 99);
      cls = (r < 20) ? C_ALU  : (r < 40) ? C_ALU_WB : (r < 62) ? C_LOAD : (r < 84) ? C_STORE :
            (r < 89) ? C_HALT : (r < 94) ? C_DERR   : (r < 97) ? C_LDST : C_HALT_ERR;
      fw  = $urandom_range(0, 5);
      mw  = $urandom_range(0, 5);
      ab  = 0;
      if (fw > 0 && $urandom_range(0, 29) == 0) ab = 1;
      else if ((cls == C_LOAD || cls == C_STORE) && mw > 0 && $urandom_range(0, 29) == 0) ab = 2;
      run_instr(cls, fw, mw, ab);
    end

    repeat (2) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: actual pending=%0d required pending=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
